// File: rtl/mips_int_pkg.sv
// mips_int_pkg: register map, FSM encoding and ACTIVE bit positions for int_ctrl
package mips_int_pkg;
  localparam logic [1:0] INT_CTRL   = 2'd0;
  localparam logic [1:0] INT_MASK   = 2'd1;
  localparam logic [1:0] INT_PEND   = 2'd2;
  localparam logic [1:0] INT_ACTIVE = 2'd3;
  localparam int ACT_SERVICE_BIT = 31;
  localparam int ACT_INT_BIT     = 30;
  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;
endpackage

// File: rtl/int_prio_enc.sv
// int_prio_enc: lowest-index-first priority encoder with valid flag
module int_prio_enc #(
  parameter int NSRC    = 8,
  parameter int CAUSE_W = 3
) (
  input  logic [NSRC-1:0]    req,
  output logic [CAUSE_W-1:0] idx,
  output logic               valid
);
  // scan from the top so the lowest set index is written last and wins
  always_comb begin
    idx   = '0;
    valid = |req;
    for (int i = NSRC - 1; i >= 0; i--)
      if (req[i]) idx = CAUSE_W'(i);
  end
endmodule

// File: rtl/int_ctrl.sv
// int_ctrl: edge-capturing interrupt controller with request/ack/eret handshake
module int_ctrl
  import mips_int_pkg::*;
#(
  parameter int NSRC    = 8,
  parameter int CAUSE_W = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NSRC-1:0]    irq_src,
  output logic               cpu_int,
  output logic [CAUSE_W-1:0] cpu_cause,
  input  logic               cpu_ack,
  input  logic               eret,
  input  logic               we,
  input  logic [1:0]         addr,
  input  logic [31:0]        wdata,
  output logic [31:0]        rdata
);
  state_t state, state_n;
  logic [NSRC-1:0] irq_prev, pending, mask, rise, eligible, w1c, ack_clr;
  logic gie, win_valid, int_n;
  logic [CAUSE_W-1:0] winner, cause_n;
  logic [31:0] active;
  assign rise     = irq_src & ~irq_prev;
  assign eligible = pending & mask & {NSRC{gie}};
  assign w1c      = (we && addr == INT_PEND) ? wdata[NSRC-1:0] : '0;
  int_prio_enc #(.NSRC(NSRC), .CAUSE_W(CAUSE_W)) u_enc (
    .req  (eligible),
    .idx  (winner),
    .valid(win_valid)
  );
  // handshake FSM: cause latched on request, not re-arbitrated until back in IDLE
  always_comb begin
    state_n = state;
    int_n   = cpu_int;
    cause_n = cpu_cause;
    ack_clr = '0;
    case (state)
      IDLE: if (win_valid) begin
        state_n = REQ;
        int_n   = 1'b1;
        cause_n = winner;
      end
      REQ: if (cpu_ack) begin
        state_n = SERVICE;
        int_n   = 1'b0;
        ack_clr = NSRC'(1) << cpu_cause;
      end else if (!eligible[cpu_cause]) begin
        state_n = IDLE;
        int_n   = 1'b0;
      end
      SERVICE: if (eret) begin
        state_n = IDLE;
        cause_n = '0;
      end
      default: state_n = IDLE;
    endcase
  end
  // state, edge history, pending capture and software registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cpu_int   <= 1'b0;
      cpu_cause <= '0;
      irq_prev  <= '1;
      pending   <= '0;
      mask      <= '0;
      gie       <= 1'b0;
    end else begin
      state     <= state_n;
      cpu_int   <= int_n;
      cpu_cause <= cause_n;
      irq_prev  <= irq_src;
      pending   <= (pending & ~w1c & ~ack_clr) | rise;
      if (we && addr == INT_CTRL) gie <= wdata[0];
      if (we && addr == INT_MASK) mask <= wdata[NSRC-1:0];
    end
  end
  // register read mux
  always_comb begin
    active                  = 32'(cpu_cause);
    active[ACT_SERVICE_BIT] = state == SERVICE;
    active[ACT_INT_BIT]     = cpu_int;
    rdata = addr == INT_CTRL ? {31'b0, gie} :
            addr == INT_MASK ? 32'(mask) :
            addr == INT_PEND ? 32'(pending) : active;
  end
endmodule
